not16_bist: RTL and testbench

//  Self-test block for a 16-bit inverter (Not16): drives vectors into its input, samples its output, checks out == ~in.

---
 rtl/not16_bist_pkg.sv | 38 +++
 rtl/not16_bist_if.sv | 37 +++
 rtl/not16_bist_lfsr16.sv | 29 ++
 rtl/not16_bist.sv | 156 +++++++++++++++
 tb/tb_not16_bist.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/not16_bist_pkg.sv
// Shared definitions for the Not16 self-test block: FSM states, stimulus table, LFSR constants.
// Optional MISR signature compaction is enabled with NOT16_BIST_MISR_EN.
package not16_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StCheck,
    StDone
  } state_e;

  localparam logic [15:0] LfsrSeed     = 16'hACE1;
  // Taps for x^16+x^14+x^13+x^11+1 on a shift-left register (bits 15, 13, 12, 10).
  localparam logic [15:0] LfsrTaps     = 16'hB400;
  localparam logic [7:0]  FailIdxNone  = 8'hFF;
  localparam logic [7:0]  NumTableVecs = 8'd5;

  function automatic logic [15:0] table_vec(input logic [2:0] i);
    logic [15:0] v;
    v = 16'h0000;
    unique case (i)
      3'd0:    v = 16'h0000;
      3'd1:    v = 16'hFFFF;
      3'd2:    v = 16'hAAAA;
      3'd3:    v = 16'h3CC3;
      3'd4:    v = 16'h1234;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  // One Fibonacci step: shift left, parity of the tapped bits enters at bit 0.
  function automatic logic [15:0] poly_step(input logic [15:0] s);
    return {s[14:0], ^(s & LfsrTaps)};
  endfunction

endpackage

// File: rtl/not16_bist_if.sv
// Bundle between the Not16 self-test block and its surroundings (control, gate under test, results).
// The slave modport is the BIST side; master is the SoC/testbench side.
interface not16_bist_if;
  logic        start;
  logic [15:0] dut_in;
  logic [15:0] dut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_count;
  logic [7:0]  first_fail_idx;
  logic [15:0] signature;

  modport slave (
    input  start,
    input  dut_out,
    output dut_in,
    output busy,
    output done,
    output pass,
    output err_count,
    output first_fail_idx,
    output signature
  );

  modport master (
    output start,
    output dut_out,
    input  dut_in,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  first_fail_idx,
    input  signature
  );
endinterface

// File: rtl/not16_bist_lfsr16.sv
// Seedable 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), shift left, feedback into bit 0.
// load has priority over step; intended for reuse by other BIST blocks.
module not16_bist_lfsr16
  import not16_bist_pkg::*;
#(
  parameter logic [15:0] Seed = LfsrSeed
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] q_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= Seed;
    end else if (load) begin
      q_q <= Seed;
    end else if (step) begin
      q_q <= poly_step(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/not16_bist.sv
// On-chip checker for a 16-bit inverter: applies vectors, waits, checks dut_out == ~dut_in.
// Define NOT16_BIST_MISR_EN to compact every sampled dut_out into a 16-bit MISR signature.
module not16_bist
  import not16_bist_pkg::*;
#(
  parameter int unsigned NUM_VECTORS   = 8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic         clock,
  input logic         reset_n,
  not16_bist_if.slave bus
);

  localparam logic [7:0]  IdxLast    = 8'(NUM_VECTORS - 1);
  localparam logic [15:0] SettleLast = 16'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] dut_in_q, dut_in_d;
  logic [7:0]  err_q, err_d;
  logic [7:0]  ffi_q, ffi_d;
  logic        pass_q, pass_d;
`ifdef NOT16_BIST_MISR_EN
  logic [15:0] sig_q, sig_d;
`endif

  logic [15:0] lfsr_q;
  logic        lfsr_load;
  logic        lfsr_step;
  logic        mismatch;

  not16_bist_lfsr16 #(
    .Seed(LfsrSeed)
  ) u_lfsr (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (lfsr_load),
    .step   (lfsr_step),
    .q      (lfsr_q)
  );

  assign mismatch = (bus.dut_out != ~dut_in_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    dut_in_d  = dut_in_q;
    err_d     = err_q;
    ffi_d     = ffi_q;
    pass_d    = pass_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
`ifdef NOT16_BIST_MISR_EN
    sig_d     = sig_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d   = StApply;
          idx_d     = 8'd0;
          err_d     = 8'd0;
          ffi_d     = FailIdxNone;
          pass_d    = 1'b0;
          lfsr_load = 1'b1;
`ifdef NOT16_BIST_MISR_EN
          sig_d     = 16'h0000;
`endif
        end
      end
      StApply: begin
        if (idx_q < NumTableVecs) begin
          dut_in_d = table_vec(idx_q[2:0]);
        end else begin
          // LFSR state is the vector itself; advance only once it has been consumed.
          dut_in_d  = lfsr_q;
          lfsr_step = 1'b1;
        end
        cnt_d   = 16'd0;
        state_d = StSettle;
      end
      StSettle: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == SettleLast) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
          if (err_q == 8'd0) begin
            ffi_d = idx_q;
          end
        end
`ifdef NOT16_BIST_MISR_EN
        sig_d = poly_step(sig_q) ^ bus.dut_out;
`endif
        idx_d = idx_q + 8'd1;
        if (idx_q == IdxLast) begin
          state_d = StDone;
          pass_d  = (err_q == 8'd0) && !mismatch;
        end else begin
          state_d = StApply;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      idx_q    <= 8'd0;
      cnt_q    <= 16'd0;
      dut_in_q <= 16'h0000;
      err_q    <= 8'd0;
      ffi_q    <= FailIdxNone;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      dut_in_q <= dut_in_d;
      err_q    <= err_d;
      ffi_q    <= ffi_d;
      pass_q   <= pass_d;
    end
  end

`ifdef NOT16_BIST_MISR_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sig_q <= 16'h0000;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign bus.signature = sig_q;
`else
  assign bus.signature = 16'h0000;
`endif

  assign bus.dut_in         = dut_in_q;
  assign bus.busy           = (state_q == StApply) || (state_q == StSettle) ||
                              (state_q == StCheck);
  assign bus.done           = (state_q == StDone);
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_not16_bist.sv
// Self-checking bench for not16_bist: three instances (8/5/255 vectors) with modelled Not16 gates,
// directed fault cases plus randomized data-dependent faults against a behavioural reference.
module tb_not16_bist;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  not16_bist_if bif_a ();
  not16_bist_if bif_b ();
  not16_bist_if bif_c ();

  not16_bist #(.NUM_VECTORS(8), .SETTLE_CYCLES(2)) u_a (
    .clock(clock), .reset_n(reset_n), .bus(bif_a.slave)
  );
  not16_bist #(.NUM_VECTORS(5), .SETTLE_CYCLES(2)) u_b (
    .clock(clock), .reset_n(reset_n), .bus(bif_b.slave)
  );
  not16_bist #(.NUM_VECTORS(255), .SETTLE_CYCLES(1)) u_c (
    .clock(clock), .reset_n(reset_n), .bus(bif_c.slave)
  );

  int unsigned nvec = 0;
  int unsigned nfail = 0;
  int          mode_v [3];
  logic [15:0] xm_v   [3];
  logic        st     [3];

  // Gate models: 0 good, 1 bit15 stuck-at-1, 2 tied low, 3 buffer, else data-dependent bit flips.
  function automatic logic [15:0] gate(input int mode, input logic [15:0] in, input logic [15:0] xm);
    case (mode)
      0:       return ~in;
      1:       return ~in | 16'h8000;
      2:       return 16'h0000;
      3:       return in;
      default: return ~in ^ (in & xm);
    endcase
  endfunction

  assign bif_a.start   = st[0];
  assign bif_b.start   = st[1];
  assign bif_c.start   = st[2];
  assign bif_a.dut_out = gate(mode_v[0], bif_a.dut_in, xm_v[0]);
  assign bif_b.dut_out = gate(mode_v[1], bif_b.dut_in, xm_v[1]);
  assign bif_c.dut_out = gate(mode_v[2], bif_c.dut_in, xm_v[2]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int inst, output logic b, output logic d, output logic p,
                        output logic [7:0] ec, output logic [7:0] ff,
                        output logic [15:0] sg, output logic [15:0] di);
    case (inst)
      0: begin
        b = bif_a.busy; d = bif_a.done; p = bif_a.pass; ec = bif_a.err_count;
        ff = bif_a.first_fail_idx; sg = bif_a.signature; di = bif_a.dut_in;
      end
      1: begin
        b = bif_b.busy; d = bif_b.done; p = bif_b.pass; ec = bif_b.err_count;
        ff = bif_b.first_fail_idx; sg = bif_b.signature; di = bif_b.dut_in;
      end
      default: begin
        b = bif_c.busy; d = bif_c.done; p = bif_c.pass; ec = bif_c.err_count;
        ff = bif_c.first_fail_idx; sg = bif_c.signature; di = bif_c.dut_in;
      end
    endcase
  endtask

  // Reference: build the vector list, pass each through the gate model, score it.
  task automatic expect_run(input int inst, input int nv, output int e_err, output int e_ff,
                            output logic e_pass, output logic [15:0] e_sig);
    logic [15:0] lf, v, o;
    int errs;
    errs  = 0;
    e_ff  = 255;
    e_sig = 16'h0000;
    lf    = 16'hACE1;
    for (int i = 0; i < nv; i++) begin
      case (i)
        0: v = 16'h0000;
        1: v = 16'hFFFF;
        2: v = 16'hAAAA;
        3: v = 16'h3CC3;
        4: v = 16'h1234;
        default: begin
          v  = lf;
          lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
        end
      endcase
      o = gate(mode_v[inst], v, xm_v[inst]);
      if (o !== ~v) begin
        if (errs == 0) e_ff = i;
        errs++;
      end
      e_sig = {e_sig[14:0], e_sig[15] ^ e_sig[13] ^ e_sig[12] ^ e_sig[10]} ^ o;
    end
    e_err  = (errs > 255) ? 255 : errs;
    e_pass = (errs == 0);
  endtask

  task automatic run(input int inst, input int nv, input int s, input bit hold);
    logic b, d, p;
    logic [7:0] ec, ff;
    logic [15:0] sg, di;
    int e_err, e_ff, cyc, lim;
    logic e_pass;
    logic [15:0] e_sig;
    expect_run(inst, nv, e_err, e_ff, e_pass, e_sig);
    lim = nv * (s + 2);
    @(negedge clock);
    st[inst] = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) st[inst] = 1'b0;
    sample(inst, b, d, p, ec, ff, sg, di);
    check("accept_busy", b, 1);
    check("accept_err_clr", ec, 0);
    check("accept_ffi_clr", ff, 8'hFF);
    check("accept_pass_clr", p, 0);
    cyc = 0;
    while (!d && cyc < lim + 8) begin
      @(posedge clock);
      #1;
      cyc++;
      sample(inst, b, d, p, ec, ff, sg, di);
      if (cyc == lim - 1) begin
        check("last_busy_cycle_pass", p, 0);
        check("last_busy_cycle_done", d, 0);
      end
    end
    st[inst] = 1'b0;
    check("done_edge", cyc, lim);
    check("done_busy", b, 0);
    check("err_count", ec, e_err);
    check("first_fail_idx", ff, e_ff);
    check("pass", p, e_pass);
`ifdef NOT16_BIST_MISR_EN
    check("signature", sg, e_sig);
`else
    check("signature", sg, 0);
`endif
  endtask

  initial begin
    logic b, d, p;
    logic [7:0] ec, ff;
    logic [15:0] sg, di;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; mode_v[i] = 0; xm_v[i] = 16'h0000;
    end
    repeat (2) @(posedge clock);
    #1;
    sample(0, b, d, p, ec, ff, sg, di);
    check("rst_busy", b, 0);
    check("rst_done", d, 0);
    check("rst_pass", p, 0);
    check("rst_err", ec, 0);
    check("rst_ffi", ff, 8'hFF);
    check("rst_sig", sg, 0);
    check("rst_dut_in", di, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Good inverter, default configuration.
    run(0, 8, 2, 0);
    sample(0, b, d, p, ec, ff, sg, di);
    check("t1_pass", p, 1);

    // bit15 stuck-at-1 on a 5-vector run: only 16'hFFFF and 16'hAAAA expose it.
    mode_v[1] = 1;
    run(1, 5, 2, 0);
    sample(1, b, d, p, ec, ff, sg, di);
    check("t2_err", ec, 2);
    check("t2_ffi", ff, 1);

    // Tied-low output across 255 vectors, then all-mismatch saturation, then 8 vectors.
    mode_v[2] = 2;
    run(2, 255, 1, 0);
    mode_v[2] = 3;
    run(2, 255, 1, 0);
    sample(2, b, d, p, ec, ff, sg, di);
    check("t3_saturate", ec, 255);
    mode_v[0] = 2;
    run(0, 8, 2, 0);
    sample(0, b, d, p, ec, ff, sg, di);
    check("t3_err8", ec, 7);

    // start held through a run begun from DONE: results cleared, no restart while busy.
    mode_v[0] = 0;
    run(0, 8, 2, 1);
    repeat (3) @(posedge clock);
    #1;
    sample(0, b, d, p, ec, ff, sg, di);
    check("t5_done_holds", d, 1);
    check("t5_pass_holds", p, 1);

    // Randomized data-dependent faults on both small instances.
    for (int r = 0; r < 6; r++) begin
      mode_v[r % 2] = 4;
      xm_v[r % 2] = (16'h0001 << $urandom_range(15)) | ((r % 3 == 0) ? 16'h0000 :
                    (16'h0001 << $urandom_range(15)));
      repeat ($urandom_range(0, 4)) @(negedge clock);
      run(r % 2, (r % 2 == 0) ? 8 : 5, 2, 0);
    end

    // Asynchronous reset ten edges into a failing run.
    mode_v[0] = 3;
    @(negedge clock);
    st[0] = 1'b1;
    @(posedge clock);
    #1;
    st[0] = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    sample(0, b, d, p, ec, ff, sg, di);
    check("t4_pre_reset_err", ec, 2);
    reset_n = 1'b0;
    #1;
    sample(0, b, d, p, ec, ff, sg, di);
    check("t4_busy", b, 0);
    check("t4_done", d, 0);
    check("t4_pass", p, 0);
    check("t4_err", ec, 0);
    check("t4_ffi", ff, 8'hFF);
    check("t4_sig", sg, 0);
    check("t4_dut_in", di, 0);
    @(negedge clock);
    reset_n = 1'b1;
    mode_v[0] = 0;
    run(0, 8, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
